// File: rtl/stream_frame_loader.sv
// stream_frame_loader: parses a framed 32-bit stream into SRAM bank writes.
// Each frame starts with HDR_WORDS header words: word 0 carries the start
// address and bank, word 1 the payload length, the rest are ignored. Payload
// beats are then written one per transfer to the selected bank, with length
// and bank errors flagged and the remainder of a bad frame drained.
//
// Stream handshake: a beat moves on a cycle where s_axis_tvalid and
// s_axis_tready are both high; the source holds tdata/tlast stable while
// tvalid is high and tready is low. tready depends only on state and
// fabric_busy, never on tvalid.
`timescale 1ns/1ps
module stream_frame_loader #(
  parameter int BANKS     = 2,
  parameter int SRAM_AW   = 12,
  parameter int SRAM_DW   = 24,
  parameter int HDR_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic               fabric_busy,
  input  logic               clear_stats,
  output logic [BANKS-1:0]   sram_we,
  output logic [SRAM_AW-1:0] sram_waddr,
  output logic [SRAM_DW-1:0] sram_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_len,
  output logic               err_bank,
  output logic [15:0]        words_written,
  output logic [31:0]        wait_cycles,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [2:0]         bank_q, bank_d;
  logic [15:0]        hdr_cnt_q, hdr_cnt_d;
  logic [15:0]        frame_len_q, frame_len_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [15:0]        words_written_q, words_written_d;
  logic [31:0]        wait_cycles_q, wait_cycles_d;
  logic               err_len_q, err_len_d;
  logic               err_bank_q, err_bank_d;
  logic [BANKS-1:0]   sram_we_q, sram_we_d;
  logic [SRAM_AW-1:0] sram_waddr_q, sram_waddr_d;
  logic [SRAM_DW-1:0] sram_wdata_q, sram_wdata_d;

  logic        xfer;
  logic [15:0] len_eff;
  logic        bank_bad;
  logic        unused_tdata;

  // Only some tdata bits are meaningful; fold the rest so none dangle.
  assign unused_tdata = ^s_axis_tdata;

  // Ready is a pure function of state (and fabric ownership while in DATA).
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      IDLE, HEADER, DRAIN: s_axis_tready = 1'b1;
      DATA:                s_axis_tready = ~fabric_busy;
      default:             s_axis_tready = 1'b0;
    endcase
  end

  assign xfer = s_axis_tvalid & s_axis_tready;

  // With HDR_WORDS==2 the length arrives on the same beat that ends the header.
  assign len_eff  = (hdr_cnt_q == 16'd1) ? s_axis_tdata[15:0] : frame_len_q;
  assign bank_bad = (32'(bank_q) >= 32'(BANKS));

  // Next-state and datapath: header parsing, payload writes, error handling.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    bank_d          = bank_q;
    hdr_cnt_d       = hdr_cnt_q;
    frame_len_d     = frame_len_q;
    remaining_d     = remaining_q;
    words_written_d = words_written_q;
    err_len_d       = err_len_q;
    err_bank_d      = err_bank_q;
    sram_we_d       = '0;
    sram_waddr_d    = sram_waddr_q;
    sram_wdata_d    = sram_wdata_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          addr_d          = s_axis_tdata[SRAM_AW-1:0];
          bank_d          = s_axis_tdata[SRAM_AW+2:SRAM_AW];
          err_len_d       = 1'b0;
          err_bank_d      = 1'b0;
          words_written_d = 16'd0;
          hdr_cnt_d       = 16'd1;
          if (s_axis_tlast) begin
            err_len_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = HEADER;
          end
        end
      end
      HEADER: begin
        if (xfer) begin
          if (hdr_cnt_q == 16'd1) frame_len_d = s_axis_tdata[15:0];
          if (s_axis_tlast) begin
            err_len_d = 1'b1;
            state_d   = DONE;
          end else if (hdr_cnt_q == 16'(HDR_WORDS - 1)) begin
            remaining_d = len_eff;
            if (bank_bad) begin
              err_bank_d = 1'b1;
              state_d    = DRAIN;
            end else if (len_eff == 16'd0) begin
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 16'd1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          for (int i = 0; i < BANKS; i++) sram_we_d[i] = (32'(bank_q) == i);
          sram_waddr_d    = addr_q;
          sram_wdata_d    = s_axis_tdata[SRAM_DW-1:0];
          addr_d          = addr_q + SRAM_AW'(1);
          words_written_d = words_written_q + 16'd1;
          remaining_d     = remaining_q - 16'd1;
          if (s_axis_tlast) begin
            if (remaining_q != 16'd1) err_len_d = 1'b1;
            state_d = DONE;
          end else if (remaining_q == 16'd1) begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer && s_axis_tlast) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall counter: counts DATA cycles without a transfer, saturating.
  always_comb begin
    wait_cycles_d = wait_cycles_q;
    if (clear_stats) begin
      wait_cycles_d = 32'd0;
    end else if (state_q == DATA && !xfer && wait_cycles_q != 32'hFFFF_FFFF) begin
      wait_cycles_d = wait_cycles_q + 32'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      bank_q          <= '0;
      hdr_cnt_q       <= '0;
      frame_len_q     <= '0;
      remaining_q     <= '0;
      words_written_q <= '0;
      wait_cycles_q   <= '0;
      err_len_q       <= 1'b0;
      err_bank_q      <= 1'b0;
      sram_we_q       <= '0;
      sram_waddr_q    <= '0;
      sram_wdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      bank_q          <= bank_d;
      hdr_cnt_q       <= hdr_cnt_d;
      frame_len_q     <= frame_len_d;
      remaining_q     <= remaining_d;
      words_written_q <= words_written_d;
      wait_cycles_q   <= wait_cycles_d;
      err_len_q       <= err_len_d;
      err_bank_q      <= err_bank_d;
      sram_we_q       <= sram_we_d;
      sram_waddr_q    <= sram_waddr_d;
      sram_wdata_q    <= sram_wdata_d;
    end
  end

  assign sram_we       = sram_we_q;
  assign sram_waddr    = sram_waddr_q;
  assign sram_wdata    = sram_wdata_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err_len       = err_len_q;
  assign err_bank      = err_bank_q;
  assign words_written = words_written_q;
  assign wait_cycles   = wait_cycles_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/stream_frame_loader.md
STREAM_FRAME_LOADER -- requirements
Module: stream_frame_loader

Interface
REQ-001 SHALL have parameter BANKS, default 2: number of SRAM banks, 1..8.
REQ-002 SHALL have parameter SRAM_AW, default 12: SRAM address width.
REQ-003 SHALL have parameter SRAM_DW, default 24: SRAM data width, at most 32.
REQ-004 SHALL have parameter HDR_WORDS, default 4: header words per frame, at least 2.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port s_axis_tdata, input, 32: stream data.
REQ-008 SHALL have port s_axis_tvalid, input, 1: stream valid.
REQ-009 SHALL have port s_axis_tready, output, 1: stream ready.
REQ-010 SHALL have port s_axis_tlast, input, 1: marks the final beat of a frame.
REQ-011 SHALL have port fabric_busy, input, 1: the engine owns the SRAM; SRAM writes are blocked.
REQ-012 SHALL have port clear_stats, input, 1: synchronous clear of wait_cycles.
REQ-013 SHALL have port sram_we, output, BANKS: one-hot bank write enable.
REQ-014 SHALL have port sram_waddr, output, SRAM_AW: write address.
REQ-015 SHALL have port sram_wdata, output, SRAM_DW: write data.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-018 SHALL have port err_len, output, 1: sticky length-mismatch flag.
REQ-019 SHALL have port err_bank, output, 1: sticky bad-bank flag.
REQ-020 SHALL have port words_written, output, 16: writes issued in the current frame.
REQ-021 SHALL have port wait_cycles, output, 32: saturating stall counter.

Function
REQ-022 SHALL define transfer as s_axis_tvalid & s_axis_tready; s_axis_tready SHALL be combinational from state: 1 in IDLE/HEADER/DRAIN, ~fabric_busy in DATA, 0 in DONE.
REQ-023 SHALL have FSM states IDLE, HEADER, DATA, DRAIN, DONE.
REQ-024 SHALL, on an IDLE transfer (header word 0), latch start address = tdata[SRAM_AW-1:0] and bank = tdata[SRAM_AW+2:SRAM_AW]; clear err_len, err_bank and words_written; set hdr_cnt=1; go to HEADER.
REQ-025 SHALL, in HEADER, latch frame_len = tdata[15:0] on the hdr_cnt==1 transfer; ignore payload of words 2..HDR_WORDS-1.
REQ-026 SHALL, on the transfer with hdr_cnt==HDR_WORDS-1, go to DRAIN with err_bank=1 if bank>=BANKS, else DONE if frame_len==0, else DATA.
REQ-027 SHALL, on tlast during any header transfer, set err_len=1 and go to DONE.
REQ-028 SHALL, on each DATA transfer, register sram_we[bank]=1, sram_waddr=current address and sram_wdata=tdata[SRAM_DW-1:0] for exactly one cycle (latency 1); increment the address modulo 2^SRAM_AW; increment words_written; decrement remaining.
REQ-029 SHALL, on a DATA transfer with remaining==1 and tlast, go to DONE with no error.
REQ-030 SHALL, on a DATA transfer with tlast and remaining>1, set err_len and go to DONE; the beat is still written.
REQ-031 SHALL, on a DATA transfer with remaining==1 and no tlast, write the beat, set err_len and go to DRAIN.
REQ-032 SHALL, in DRAIN, consume beats with no writes until a tlast transfer, then go to DONE.
REQ-033 SHALL hold DONE for one cycle with done=1, then return to IDLE.
REQ-034 SHALL increment wait_cycles, saturating at 0xFFFFFFFF, on every DATA cycle without a transfer; clear_stats SHALL zero it and take priority.
REQ-035 SHALL keep sram_we all zero outside the cycle following a DATA transfer.

Reset
REQ-036 SHALL, while reset_n is low, force state=IDLE; sram_we, sram_waddr, sram_wdata, done, err_len, err_bank, words_written and wait_cycles all 0; s_axis_tready=1 immediately after deassertion.
REQ-037 SHALL, on reset mid-frame, abandon the frame without issuing further writes; the next beat is taken as header word 0.

Verification
REQ-038 Frame 0x005, 3, 0, 0, then data A, B, C with tlast on C -> bank0 writes at 0x005/0x006/0x007, done pulse, words_written=3, no errors.
REQ-039 Header word 0 = 0x1FFE (bank1, addr 0xFFE), len 3 -> writes at 0xFFE, 0xFFF, 0x000 on sram_we=2'b10.
REQ-040 Header len 4 but tlast on data beat 2 -> 2 writes, err_len=1, done pulse.
REQ-041 Header bank field 5 with BANKS=2, 2 data beats then tlast -> no writes, err_bank=1, done pulse.
REQ-042 fabric_busy high for 5 DATA cycles with tvalid=1 -> tready=0, no writes, wait_cycles=5; write resumes on the cycle after release.
REQ-043 reset_n pulsed low after the 2nd data beat of a len-8 frame -> all outputs 0; the next frame loads correctly from its own header.
